// File: rtl/gn_mdl_reset_seq.sv
// gn_mdl_reset_seq: power-up / on-demand reset sequencer.
// Holds all P_CH channels in reset for P_HOLD quiet cycles of req. It then
// releases channel 0, and channels 1..P_CH-1 one at a time every P_STEP
// cycles. rdy is set together with the last channel.
//
// Optional build macro: GN_MDL_RESET_SEQ_EVT_CNT_EN adds evt_cnt, a
// saturating 8-bit count of req-triggered returns to ASSERT.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_ASSERT  | all channels in reset, counting consecutive req=0 cycles
// ST_RELEASE | channels coming out of reset in order 0..P_CH-1
// ST_RUN     | all channels released, rdy=1
`timescale 1ns/1ps

module gn_mdl_reset_seq #(
  parameter int unsigned P_CH   = 4,
  parameter int unsigned P_HOLD = 32'd16,
  parameter int unsigned P_STEP = 32'd4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  output logic [P_CH-1:0] reset_n,
  output logic            rdy,
  output logic            busy
`ifdef GN_MDL_RESET_SEQ_EVT_CNT_EN
  ,
  output logic [7:0]      evt_cnt
`endif
);

  localparam int unsigned LP_MAX = (P_HOLD > P_STEP) ? P_HOLD : P_STEP;
  localparam int unsigned LP_CW  = $clog2(LP_MAX + 1);

  // Terminal counts: the counters run 0..N-1, so the N-th cycle matches.
  localparam logic [LP_CW-1:0] LP_HOLD_TC = LP_CW'(P_HOLD - 1);
  localparam logic [LP_CW-1:0] LP_STEP_TC = LP_CW'(P_STEP - 1);
  localparam logic [LP_CW-1:0] LP_CNT_ONE = LP_CW'(1);
  localparam logic [P_CH-1:0]  LP_CH0     = P_CH'(1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LP_CW-1:0] r_hold;
  logic [LP_CW-1:0] w_hold_nxt;
  logic [LP_CW-1:0] r_step;
  logic [LP_CW-1:0] w_step_nxt;
  logic [P_CH-1:0]  r_rst_n;
  logic [P_CH-1:0]  w_rst_n_nxt;
  logic [P_CH-1:0]  w_rst_n_shift;
  logic             r_rdy;
  logic             w_rdy_nxt;
  logic             r_busy;

  // Released channels form a thermometer code from bit 0 upward. Shifting
  // in a 1 therefore releases exactly the next channel and keeps the
  // channels that are already released. When P_CH is 1 the shifted-out bit
  // is simply dropped.
  assign w_rst_n_shift = (r_rst_n << 1) | LP_CH0;

  // State register and all registered outputs. reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_ASSERT;
      r_hold  <= '0;
      r_step  <= '0;
      r_rst_n <= '0;
      r_rdy   <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_step  <= w_step_nxt;
      r_rst_n <= w_rst_n_nxt;
      r_rdy   <= w_rdy_nxt;
      r_busy  <= ~w_rdy_nxt;
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_step_nxt  = r_step;
    w_rst_n_nxt = r_rst_n;
    w_rdy_nxt   = r_rdy;

    case (r_state)
      ST_ASSERT: begin
        w_rst_n_nxt = '0;
        w_rdy_nxt   = 1'b0;
        w_step_nxt  = '0;
        if (req) begin
          // Any request restarts the quiet-period count from zero.
          w_hold_nxt = '0;
        end else if (r_hold == LP_HOLD_TC) begin
          w_hold_nxt  = '0;
          w_rst_n_nxt = LP_CH0;
          if (&LP_CH0) begin
            // Single channel: the first release is also the last one.
            w_state_nxt = ST_RUN;
            w_rdy_nxt   = 1'b1;
          end else begin
            w_state_nxt = ST_RELEASE;
          end
        end else begin
          w_hold_nxt = r_hold + LP_CNT_ONE;
        end
      end

      ST_RELEASE: begin
        if (req) begin
          w_state_nxt = ST_ASSERT;
          w_rst_n_nxt = '0;
          w_rdy_nxt   = 1'b0;
          w_hold_nxt  = '0;
          w_step_nxt  = '0;
        end else if (r_step == LP_STEP_TC) begin
          w_step_nxt  = '0;
          w_rst_n_nxt = w_rst_n_shift;
          if (&w_rst_n_shift) begin
            w_state_nxt = ST_RUN;
            w_rdy_nxt   = 1'b1;
          end
        end else begin
          w_step_nxt = r_step + LP_CNT_ONE;
        end
      end

      ST_RUN: begin
        w_rst_n_nxt = '1;
        w_rdy_nxt   = 1'b1;
        if (req) begin
          w_state_nxt = ST_ASSERT;
          w_rst_n_nxt = '0;
          w_rdy_nxt   = 1'b0;
          w_hold_nxt  = '0;
          w_step_nxt  = '0;
        end
      end

      default: begin
        // Unreachable encoding: fall back to the safe, all-in-reset state.
        w_state_nxt = ST_ASSERT;
        w_rst_n_nxt = '0;
        w_rdy_nxt   = 1'b0;
        w_hold_nxt  = '0;
        w_step_nxt  = '0;
      end
    endcase
  end

  assign reset_n = r_rst_n;
  assign rdy     = r_rdy;
  assign busy    = r_busy;

`ifdef GN_MDL_RESET_SEQ_EVT_CNT_EN
  logic [7:0] r_evt_cnt;
  logic       w_evt_hit;

  // Only a request seen outside ASSERT counts as a re-entry. Requests seen
  // while already in ASSERT just restart the hold count.
  assign w_evt_hit = req && ((r_state == ST_RELEASE) || (r_state == ST_RUN))
                     && (r_evt_cnt != 8'hFF);

  // Saturating re-entry counter. Only reset clears it, and reset also
  // blocks a req that arrives in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_evt_cnt <= '0;
    end else if (w_evt_hit) begin
      r_evt_cnt <= r_evt_cnt + 8'd1;
    end
  end

  assign evt_cnt = r_evt_cnt;
`endif

endmodule

// File: tb/tb_gn_mdl_reset_seq.sv
// Bench for gn_mdl_reset_seq. The stimulus pushes each expected output change
// (the cycle it lands on and the output values) into a per-DUT queue. A
// negedge monitor pops one entry every time a DUT output changes and
// compares it. dut4 uses the default parameters; dut1 uses P_CH=1, P_STEP=1.
`timescale 1ns/1ps

module tb_gn_mdl_reset_seq;

`ifdef GN_MDL_RESET_SEQ_EVT_CNT_EN
  localparam bit EVT_EN = 1'b1;
`else
  localparam bit EVT_EN = 1'b0;
`endif

  typedef struct {
    int cyc;
    int rn;
    int rdy;
    int busy;
    int evt;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       req;
  logic       req2;
  logic [3:0] rn4;
  logic       rdy4, busy4;
  logic [0:0] rn1;
  logic       rdy1, busy1;
  logic [7:0] evt4, evt1;

  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   done   = 1'b0;
  exp_t q4[$];
  exp_t q1[$];
  logic [13:0] p4 = 'x;
  logic [10:0] p1 = 'x;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gn_mdl_reset_seq #(.P_CH(4), .P_HOLD(32'd16), .P_STEP(32'd4)) dut4 (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .reset_n (rn4),
    .rdy     (rdy4),
    .busy    (busy4)
`ifdef GN_MDL_RESET_SEQ_EVT_CNT_EN
    ,
    .evt_cnt (evt4)
`endif
  );

  gn_mdl_reset_seq #(.P_CH(1), .P_HOLD(32'd16), .P_STEP(32'd1)) dut1 (
    .clk     (clk),
    .reset   (reset),
    .req     (req2),
    .reset_n (rn1),
    .rdy     (rdy1),
    .busy    (busy1)
`ifdef GN_MDL_RESET_SEQ_EVT_CNT_EN
    ,
    .evt_cnt (evt1)
`endif
  );

`ifndef GN_MDL_RESET_SEQ_EVT_CNT_EN
  assign evt4 = 8'd0;
  assign evt1 = 8'd0;
`endif

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic push4(input int c, input int rn, input int rdy, input int evt);
    exp_t e;
    e.cyc = c; e.rn = rn; e.rdy = rdy; e.busy = rdy ? 0 : 1;
    e.evt = EVT_EN ? evt : 0;
    q4.push_back(e);
  endtask

  task automatic push1(input int c, input int rn, input int rdy, input int evt);
    exp_t e;
    e.cyc = c; e.rn = rn; e.rdy = rdy; e.busy = rdy ? 0 : 1;
    e.evt = EVT_EN ? evt : 0;
    q1.push_back(e);
  endtask

  // Release of dut4 after the quiet period that begins once cycle 'base'
  // is over: the channels come up at +16, +20, +24 and +28, and rdy rises
  // with the last one. Only the first 'n' steps are queued.
  task automatic rel4(input int base, input int n, input int evt);
    int off [4];
    int val [4];
    off = '{16, 20, 24, 28};
    val = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    for (int k = 0; k < n; k++)
      push4(base + off[k], val[k], (k == 3) ? 1 : 0, evt);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Monitor: every observed output change must match the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if ({rn4, rdy4, busy4, evt4} !== p4) begin
      p4 = {rn4, rdy4, busy4, evt4};
      if (q4.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL dut4_unexpected_change at cycle %0d: got reset_n=%b rdy=%b evt=%0d, expected no change",
                 cyc, rn4, rdy4, evt4);
      end else begin
        e = q4.pop_front();
        chk("dut4_when",    cyc,          e.cyc);
        chk("dut4_reset_n", int'(rn4),    e.rn);
        chk("dut4_rdy",     int'(rdy4),   e.rdy);
        chk("dut4_busy",    int'(busy4),  e.busy);
        chk("dut4_evt_cnt", int'(evt4),   e.evt);
      end
    end
    if ({rn1, rdy1, busy1, evt1} !== p1) begin
      p1 = {rn1, rdy1, busy1, evt1};
      if (q1.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL dut1_unexpected_change at cycle %0d: got reset_n=%b rdy=%b evt=%0d, expected no change",
                 cyc, rn1, rdy1, evt1);
      end else begin
        e = q1.pop_front();
        chk("dut1_when",    cyc,          e.cyc);
        chk("dut1_reset_n", int'(rn1),    e.rn);
        chk("dut1_rdy",     int'(rdy1),   e.rdy);
        chk("dut1_busy",    int'(busy1),  e.busy);
        chk("dut1_evt_cnt", int'(evt1),   e.evt);
      end
    end
    if (done || cyc > 20000) begin
      if (!done) begin
        n_chk++; n_fail++;
        $display("FAIL timeout: got cycle %0d, expected stimulus done by 20000", cyc);
      end
      chk("dut4_queue_drained", q4.size(), 0);
      chk("dut1_queue_drained", q1.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  end

  initial begin
    int c;
    int base;
    reset = 1'b1;
    req   = 1'b0;
    req2  = 1'b0;

    // Power-up: three reset edges, after which both DUTs show reset values
    // from edge 1. Once reset falls, dut4 releases at +16/20/24/28 and dut1
    // releases at +16.
    push4(1, 0, 0, 0);
    push1(1, 0, 0, 0);
    repeat (3) tick();
    reset = 1'b0;
    rel4(cyc, 4, 0);
    push1(cyc + 16, 1, 1, 0);
    repeat (35) tick();

    // One-cycle req in RUN on both DUTs: all channels drop at the next edge
    // and the release repeats 16 cycles after req falls.
    c = cyc;
    req = 1'b1; req2 = 1'b1;
    push4(c + 1, 0, 0, 1);
    push1(c + 1, 0, 0, 1);
    tick();
    req = 1'b0; req2 = 1'b0;
    rel4(cyc, 4, 1);
    push1(cyc + 16, 1, 1, 1);
    repeat (35) tick();

    // req held for 50 cycles keeps dut4 in ASSERT. A later one-cycle req,
    // 10 quiet cycles into the hold, must restart the count without
    // counting as a re-entry.
    c = cyc;
    req = 1'b1;
    push4(c + 1, 0, 0, 2);
    repeat (50) tick();
    req = 1'b0;
    repeat (10) tick();
    req = 1'b1;
    tick();
    req = 1'b0;
    base = cyc;
    rel4(base, 2, 2);

    // req while reset_n = 0011: everything drops, and a full restart follows.
    repeat (21) tick();
    req = 1'b1;
    push4(cyc + 1, 0, 0, 3);
    tick();
    req = 1'b0;
    rel4(cyc, 4, 3);
    repeat (35) tick();

    // reset and req together in RUN: reset wins, and evt_cnt clears.
    c = cyc;
    reset = 1'b1; req = 1'b1;
    push4(c + 1, 0, 0, 0);
    push1(c + 1, 0, 0, 0);
    tick();
    reset = 1'b0; req = 1'b0;
    rel4(cyc, 4, 0);
    push1(cyc + 16, 1, 1, 0);
    repeat (35) tick();

`ifdef GN_MDL_RESET_SEQ_EVT_CNT_EN
    // 300 re-entries. Each one is taken out of RELEASE right after
    // channel 0 rises; evt_cnt must stop at 255.
    c = cyc;
    req = 1'b1;
    push4(c + 1, 0, 0, 1);
    tick();
    req = 1'b0;
    base = cyc;
    for (int i = 2; i <= 300; i++) begin
      push4(base + 16, 4'b0001, 0, sat(i - 1));
      repeat (16) tick();
      req = 1'b1;
      push4(cyc + 1, 0, 0, sat(i));
      tick();
      req = 1'b0;
      base = cyc;
    end
    rel4(base, 4, 255);
    repeat (35) tick();
`endif

    done = 1'b1;
  end

endmodule
